fft_int2fp_stream: RTL
======================

// Module: fft_int2fp_stream
// PURPOSE
//  Parametrised, handshaked successor of the fixed 4-lane FFT int-to-float converter. Converts
//  LANES complex signed-integer FFT samples per beat to IEEE-754 single precision, applying the
//  FFT block exponent. Sits between the fixed-point FFT core and the float cross-power/normalise
//  stage of rigidMC. Fully pipelined, AXI-stream style valid/ready, one beat per cycle sustained.
// PARAMETERS
//  LANES    4   complex samples per beat (1..8)
//  INT_W    32  signed integer width per real/imag component (8..32)
//  SCALE_W  8   width of signed block-exponent input
// PORTS
//  s_axi_aclk     in   1                 clock
//  s_axi_areset   in   1                 synchronous reset, active-high
//  s_valid        in   1                 input beat valid
//  s_ready        out  1                 input beat accepted when s_valid & s_ready
//  s_data         in   LANES*2*INT_W     lane k: real [2kW+W-1:2kW], imag [2kW+2W-1:2kW+W], W=INT_W
//  s_last         in   1                 end-of-frame marker, passed through
//  s_scale        in   SCALE_W           signed block exponent, sampled with the beat
//  m_valid        out  1                 output beat valid
//  m_ready        in   1                 downstream ready
//  m_data         out  LANES*64          lane k: real fp [64k+31:64k], imag fp [64k+63:64k+32]
//  m_last         out  1                 s_last delayed with its beat
//  ovf_flag       out  1                 sticky: some component saturated to +/-inf
//  unf_flag       out  1                 sticky: some component flushed to +/-0
//  flag_clr       in   1                 clears both sticky flags (synchronous)
// BEHAVIOUR
//  - Reset: m_valid=0, m_data=0, m_last=0, ovf_flag=0, unf_flag=0; all stage valids cleared;
//    in-flight beats discarded, nothing emitted for them. Reset mid-frame simply drops the frame.
//  - Pipeline: 3 stages, latency exactly 3 cycles from accept to m_valid when not stalled.
//    S1 sign + magnitude (|-2^(W-1)| held as W-bit unsigned), zero detect, register scale.
//    S2 leading-zero count, left-normalise magnitude to MSB=1, e_raw = 127 + msb_pos + scale.
//    S3 mantissa round/truncate to 23 bits, carry-out increments e_raw, range check, pack.
//  - Stall: en = !m_valid | m_ready; s_ready = en (combinational); all stages advance only on en.
//    m_data/m_last stable while m_valid & !m_ready. Bubbles are not collapsed.
//  - Zero input -> 0x00000000 (+0) regardless of scale.
//  - e_final >= 255 -> sign|0x7F800000, sets ovf_flag. e_final <= 0 -> sign|0x00000000 (no
//    denormals), sets unf_flag. e_raw computed in SCALE_W+3 signed bits, no wrap.
//  - Flags: set in cycle the offending beat is in S3 with en=1; flag_clr wins over set in the
//    same cycle; flags held until clear or reset.
//  - Each of the 2*LANES components converted independently; one shared scale per beat.
// CONFIGURATION
//  INT2FP_RNE_EN defined: round-to-nearest-even on bits below the 24-bit mantissa (guard,
//    sticky); mantissa carry renormalises (exponent+1). Only affects INT_W > 24.
//  INT2FP_RNE_EN undefined: truncate toward zero, no carry path; lower-latency S3 logic.
//  Latency (3) and interface identical in both builds.
// TESTING (LANES=4, INT_W=32, SCALE_W=8)
//  1. All lanes 1 / -1 / 0, scale 0 -> 0x3F800000 / 0xBF800000 / 0x00000000, 3 cycles later.
//  2. Input 0x80000000, scale 0 -> 0xCF000000; input 0x7FFFFFFF -> 0x4F000000 with
//     INT2FP_RNE_EN, 0x4EFFFFFF without.
//  3. Input 8, scale -3 -> 0x3F800000; input 2^30, scale +127 -> 0x7F800000, ovf_flag=1;
//     input 1, scale -127 -> 0x00000000, unf_flag=1; flag_clr -> both 0 next cycle.
//  4. 16-beat frame, s_last on beat 15, m_ready low 5 cycles mid-frame -> all 16 beats out
//     in order, m_data held during stall, m_last on beat 15 only, no loss or duplication.
//  5. Continuous s_valid, m_ready=1 -> s_ready stays 1, one output per cycle after 3-cycle fill.
//  6. Assert s_axi_areset with 2 beats in flight -> m_valid=0 next cycle, those beats never
//     appear; first post-reset beat emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/fft_int2fp_stream.sv
// fft_int2fp_stream
//   Streams LANES complex signed-integer FFT samples per beat and converts each
//   real/imag component to IEEE-754 single precision. The shared block exponent
//   s_scale is added to every component's exponent. The design is a 3-stage
//   valid/ready pipeline that sustains one beat per cycle.
//     S1: sign/magnitude split, zero detect, scale capture
//     S2: leading-one search, left-normalise, raw exponent
//     S3: mantissa rounding or truncation, range check, pack
//   Build option: define INT2FP_RNE_EN to select round-to-nearest-even.
//   Without it the mantissa is truncated toward zero.
// Ports
//   s_axi_aclk, s_axi_areset   clock, synchronous active-high reset
//   s_valid/s_ready/s_data     input beat, lane k real at [2kW +: W],
//                              lane k imag at [2kW+W +: W]
//   s_last, s_scale            frame marker and signed block exponent
//   m_valid/m_ready/m_data     output beat, lane k real fp at [64k +: 32],
//                              lane k imag fp at [64k+32 +: 32]
//   m_last                     s_last, delayed together with its beat
//   ovf_flag, unf_flag         sticky saturate / flush indicators
//   flag_clr                   synchronous clear of both sticky flags
module fft_int2fp_stream #(
  parameter int LANES   = 4,
  parameter int INT_W   = 32,
  parameter int SCALE_W = 8
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [LANES*2*INT_W-1:0]      s_data,
  input  logic                          s_last,
  input  logic signed [SCALE_W-1:0]     s_scale,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [LANES*64-1:0]           m_data,
  output logic                          m_last,
  output logic                          ovf_flag,
  output logic                          unf_flag,
  input  logic                          flag_clr
);

  localparam int NC = 2 * LANES;
  // Normalised magnitude is at least 24 bits wide so the mantissa slice always exists.
  localparam int NW = (INT_W < 24) ? 24 : INT_W;
  localparam int SW = $clog2(NW);
  // Wide enough that 127 + msb_pos + scale (+1 carry) never wraps.
  localparam int EW = (SCALE_W + 3 > 10) ? SCALE_W + 3 : 10;
  localparam logic signed [EW-1:0] E_MAX = EW'(255);
  localparam logic signed [EW-1:0] E_MIN = EW'(0);

  logic en;
  logic v1_reg, v2_reg, v3_reg;
  logic last1_reg, last2_reg, last3_reg;
  logic signed [SCALE_W-1:0] scale1_reg;
  logic ovf_reg, unf_reg;
  logic [NC-1:0] ovf_vec, unf_vec;

  // The whole pipeline moves together, so a stall freezes every stage and the output.
  assign en       = !v3_reg | m_ready;
  assign s_ready  = en;
  assign m_valid  = v3_reg;
  assign m_last   = last3_reg;
  assign ovf_flag = ovf_reg;
  assign unf_flag = unf_reg;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      v1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      v3_reg     <= 1'b0;
      last1_reg  <= 1'b0;
      last2_reg  <= 1'b0;
      last3_reg  <= 1'b0;
      scale1_reg <= '0;
    end else if (en) begin
      v1_reg     <= s_valid;
      v2_reg     <= v1_reg;
      v3_reg     <= v2_reg;
      last1_reg  <= s_last;
      last2_reg  <= last1_reg;
      last3_reg  <= last2_reg;
      scale1_reg <= s_scale;
    end
  end

  // A clear takes priority over a set in the same cycle.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else if (flag_clr) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else if (en && v2_reg) begin
      if (|ovf_vec) ovf_reg <= 1'b1;
      if (|unf_vec) unf_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_comp
      // ---------------- S1 ----------------
      logic signed [INT_W-1:0] comp;
      logic [INT_W-1:0]        mag_next;
      logic                    s1_sign_reg, s1_zero_reg;
      logic [INT_W-1:0]        s1_mag_reg;

      assign comp = s_data[gi*INT_W +: INT_W];
      // Two's-complement negate read as unsigned: the most negative value maps to 2^(W-1).
      assign mag_next = comp[INT_W-1] ? (~comp) + {{(INT_W-1){1'b0}}, 1'b1} : comp;

      always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
          s1_sign_reg <= 1'b0;
          s1_zero_reg <= 1'b0;
          s1_mag_reg  <= '0;
        end else if (en) begin
          s1_sign_reg <= comp[INT_W-1];
          s1_zero_reg <= (comp == '0);
          s1_mag_reg  <= mag_next;
        end
      end

      // ---------------- S2 ----------------
      logic [SW-1:0]          msb_pos;
      logic [SW-1:0]          shamt;
      logic [NW-1:0]          norm_next;
      logic signed [EW-1:0]   e_next;
      logic                   s2_sign_reg, s2_zero_reg;
      logic [NW-1:0]          s2_norm_reg;
      logic signed [EW-1:0]   s2_exp_reg;

      // The last set bit wins, which gives the highest one.
      always_comb begin
        msb_pos = '0;
        for (int i = 0; i < INT_W; i++) begin
          if (s1_mag_reg[i]) msb_pos = SW'(i);
        end
      end

      assign shamt     = SW'(NW - 1) - msb_pos;
      assign norm_next = NW'(s1_mag_reg) << shamt;
      assign e_next    = EW'(127) + EW'(msb_pos) + EW'(scale1_reg);

      always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
          s2_sign_reg <= 1'b0;
          s2_zero_reg <= 1'b0;
          s2_norm_reg <= '0;
          s2_exp_reg  <= '0;
        end else if (en) begin
          s2_sign_reg <= s1_sign_reg;
          s2_zero_reg <= s1_zero_reg;
          s2_norm_reg <= norm_next;
          s2_exp_reg  <= e_next;
        end
      end

      // ---------------- S3 ----------------
      logic [22:0]          mant_t, mant_f;
      logic signed [EW-1:0] e_fin;
      logic [31:0]          fp_next, fp_reg;
      logic                 ovf_c, unf_c;
      logic                 unused_norm;

      // The hidden one (MSB) is implied. Bits below the mantissa matter only when rounding.
      assign mant_t      = s2_norm_reg[NW-2 -: 23];
      assign unused_norm = ^s2_norm_reg;

`ifdef INT2FP_RNE_EN
      if (NW > 24) begin : g_rne
        logic        guard, sticky, rnd;
        logic [23:0] sum;
        assign guard = s2_norm_reg[NW-25];
        if (NW > 25) begin : g_sticky
          assign sticky = |s2_norm_reg[NW-26:0];
        end else begin : g_nosticky
          assign sticky = 1'b0;
        end
        assign rnd    = guard & (sticky | mant_t[0]);
        assign sum    = {1'b0, mant_t} + {23'd0, rnd};
        // On a carry the mantissa wraps to zero (1.11..1 + ulp = 10.0), so only the exponent moves.
        assign mant_f = sum[22:0];
        assign e_fin  = s2_exp_reg + {{(EW-1){1'b0}}, sum[23]};
      end else begin : g_exact
        assign mant_f = mant_t;
        assign e_fin  = s2_exp_reg;
      end
`else
      assign mant_f = mant_t;
      assign e_fin  = s2_exp_reg;
`endif

      always_comb begin
        fp_next = '0;
        ovf_c   = 1'b0;
        unf_c   = 1'b0;
        if (s2_zero_reg) begin
          fp_next = '0;
        end else if (e_fin >= E_MAX) begin
          fp_next = {s2_sign_reg, 8'hFF, 23'd0};
          ovf_c   = 1'b1;
        end else if (e_fin <= E_MIN) begin
          fp_next = {s2_sign_reg, 31'd0};
          unf_c   = 1'b1;
        end else begin
          fp_next = {s2_sign_reg, e_fin[7:0], mant_f};
        end
      end

      assign ovf_vec[gi] = ovf_c;
      assign unf_vec[gi] = unf_c;

      always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
          fp_reg <= '0;
        end else if (en) begin
          fp_reg <= fp_next;
        end
      end

      assign m_data[gi*32 +: 32] = fp_reg;
    end
  endgenerate

endmodule
